// File: rtl/adxl362_spi_master.sv
// adxl362_spi_master: turns start/busy/done register requests into ADXL362
// SPI mode-0 transactions (register write 0x0A, register read 0x0B,
// FIFO read 0x0D). Multi-byte reads are enabled by defining
// ADXL362_SPI_MASTER_BURST_EN; without it every read moves one data byte.
module adxl362_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [5:0] addr,
  input  logic [3:0] len,
  input  logic [7:0] wr_data,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       nCS,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(CLK_DIV - 1);
`ifdef ADXL362_SPI_MASTER_BURST_EN
  localparam int BW = 5;
`else
  localparam int BW = 2;
`endif

  localparam logic [1:0] CMD_WR   = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_FIFO = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;
  localparam logic [7:0] OP_WR    = 8'h0A;
  localparam logic [7:0] OP_RD    = 8'h0B;
  localparam logic [7:0] OP_FIFO  = 8'h0D;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [2:0]      bit_q, bit_d;
  logic [BW-1:0]   byte_q, byte_d;
  logic [BW-1:0]   last_q, last_d;
  logic [7:0]      tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [5:0]      addr_q, addr_d;
  logic [7:0]      wr_q, wr_d;
  logic            byte_rdy_q, byte_rdy_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            ncs_q, ncs_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            tmr_last_s;
  logic            is_data_s;

`ifndef ADXL362_SPI_MASTER_BURST_EN
  logic unused_len;
  assign unused_len = ^len;
`endif

  // Byte to shift out at position idx of a transaction of kind c.
  function automatic logic [7:0] tx_byte(input logic [1:0] c, input logic [BW-1:0] idx,
                                         input logic [5:0] a, input logic [7:0] w);
    logic [7:0] b;
    b = 8'h00;
    if (idx == {BW{1'b0}}) begin
      case (c)
        CMD_WR:  b = OP_WR;
        CMD_RD:  b = OP_RD;
        default: b = OP_FIFO;
      endcase
    end else if (idx == BW'(1'b1)) begin
      b = (c == CMD_FIFO) ? 8'h00 : {2'b00, a};
    end else if (c == CMD_WR) begin
      b = w;
    end else begin
      b = 8'h00;
    end
    return b;
  endfunction

  // Next-state, counters and next values of every registered output.
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    last_d     = last_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    byte_rdy_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ncs_d      = ncs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    tmr_last_s = (tmr_q == TMR_LAST);

    if (cmd_q == CMD_RD) begin
      is_data_s = (byte_q >= BW'(2'd2));
    end else if (cmd_q == CMD_FIFO) begin
      is_data_s = (byte_q != {BW{1'b0}});
    end else begin
      is_data_s = 1'b0;
    end

    // A completed data byte is published one cycle after its last sample.
    if (byte_rdy_q) begin
      rd_data_d  = rx_q;
      rd_valid_d = 1'b1;
    end else begin
      rd_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        ncs_d  = 1'b1;
        mosi_d = 1'b0;
        busy_d = 1'b0;
        if (start && (cmd != CMD_RSVD)) begin
          state_d = S_SETUP;
          tmr_d   = {TW{1'b0}};
          bit_d   = 3'd0;
          byte_d  = {BW{1'b0}};
          cmd_d   = cmd;
          addr_d  = addr;
          wr_d    = wr_data;
`ifdef ADXL362_SPI_MASTER_BURST_EN
          if (cmd == CMD_WR) begin
            last_d = 5'd2;
          end else if (cmd == CMD_RD) begin
            last_d = 5'd2 + {1'b0, len};
          end else begin
            last_d = 5'd1 + {1'b0, len};
          end
`else
          last_d = (cmd == CMD_FIFO) ? 2'd1 : 2'd2;
`endif
          tx_d    = tx_byte(cmd, {BW{1'b0}}, addr, wr_data);
          mosi_d  = tx_d[7];
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (tmr_last_s) begin
          state_d = S_SHIFT;
          tmr_d   = {TW{1'b0}};
        end else begin
          tmr_d = tmr_q + TW'(1'b1);
        end
      end
      S_SHIFT: begin
        if (!tmr_last_s) begin
          tmr_d = tmr_q + TW'(1'b1);
        end else if (!sclk_q) begin
          // Rising edge: sample MISO, flag a finished data byte.
          tmr_d      = {TW{1'b0}};
          sclk_d     = 1'b1;
          rx_d       = {rx_q[6:0], MISO};
          byte_rdy_d = (bit_q == 3'd7) && is_data_s;
        end else begin
          // Falling edge: present the next bit at the start of the low phase.
          tmr_d  = {TW{1'b0}};
          sclk_d = 1'b0;
          if (bit_q != 3'd7) begin
            bit_d  = bit_q + 3'd1;
            tx_d   = {tx_q[6:0], 1'b0};
            mosi_d = tx_q[6];
          end else if (byte_q != last_q) begin
            bit_d  = 3'd0;
            byte_d = byte_q + BW'(1'b1);
            tx_d   = tx_byte(cmd_q, byte_q + BW'(1'b1), addr_q, wr_q);
            mosi_d = tx_d[7];
          end else begin
            state_d = S_HOLD;
            mosi_d  = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (tmr_last_s) begin
          state_d = S_GAP;
          tmr_d   = {TW{1'b0}};
          ncs_d   = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1'b1);
        end
      end
      S_GAP: begin
        if (tmr_last_s) begin
          state_d = S_IDLE;
          tmr_d   = {TW{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        ncs_d   = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tmr_q      <= {TW{1'b0}};
      bit_q      <= 3'd0;
      byte_q     <= {BW{1'b0}};
      last_q     <= {BW{1'b0}};
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      cmd_q      <= 2'b00;
      addr_q     <= 6'd0;
      wr_q       <= 8'h00;
      byte_rdy_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ncs_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      last_q     <= last_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wr_q       <= wr_d;
      byte_rdy_q <= byte_rdy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ncs_q      <= ncs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign SCLK     = sclk_q;
  assign MOSI     = mosi_q;
  assign nCS      = ncs_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_adxl362_spi_master.sv
// tb_adxl362_spi_master: drives random and directed requests into the SPI
// master, emulates an ADXL362 register file / FIFO on the pins and compares
// MOSI bytes, read data, latency and pin timing against a reference model.
module tb_adxl362_spi_master;
  localparam int CLK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, start, miso;
  logic [1:0] cmd;
  logic [5:0] addr;
  logic [3:0] len;
  logic [7:0] wr_data;
  logic       sclk, mosi, ncs, busy, done, rd_valid;
  logic [7:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Reference model state and slave storage (kept separately).
  logic [7:0] ref_mem [64];
  logic [7:0] s_mem [64];
  logic [7:0] fifo_mem [16];
  logic [7:0] mosi_log [$];

  adxl362_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd), .addr(addr), .len(len),
    .wr_data(wr_data), .MISO(miso), .SCLK(sclk), .MOSI(mosi), .nCS(ncs),
    .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural ADXL362 slave: mode 0, samples MOSI on SCLK rise, drives MISO after fall.
  logic [7:0] s_sh = 8'h00, s_op = 8'h00, s_out = 8'h00;
  logic [5:0] s_addr = 6'd0;
  int s_bits = 0, s_bytes = 0;
  logic p_sclk = 1'b0;
  always @(negedge clk) begin
    if (ncs !== 1'b0) begin
      s_bits = 0; s_bytes = 0; s_out = 8'h00; miso = 1'b0;
    end else if (sclk && !p_sclk) begin
      s_sh = {s_sh[6:0], mosi};
      s_bits++;
      if (s_bits == 8) begin
        mosi_log.push_back(s_sh);
        if (s_bytes == 0) s_op = s_sh;
        else if (s_bytes == 1 && s_op != 8'h0D) s_addr = s_sh[5:0];
        else if (s_bytes == 2 && s_op == 8'h0A) s_mem[s_addr] = s_sh;
        s_bytes++;
        s_bits = 0;
        if (s_op == 8'h0B && s_bytes >= 2) s_out = s_mem[s_addr + 6'(s_bytes - 2)];
        else if (s_op == 8'h0D && s_bytes >= 1) s_out = fifo_mem[(s_bytes - 1) % 16];
        else s_out = 8'h00;
      end
    end else if (!sclk && p_sclk) begin
      miso = s_out[7 - s_bits];
    end
    p_sclk = sclk;
  end

  // Pin timing monitor: SCLK phase lengths, MOSI stability, nCS high time.
  int run = 1, ncs_hi_run = 1000, phase_err = 0, mosi_err = 0, ncs_err = 0, idle_sclk_err = 0;
  bit seen_high = 1'b0;
  logic p2_sclk = 1'b0, p2_ncs = 1'b1, p2_mosi = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      if (ncs) begin
        if (sclk) idle_sclk_err++;
        seen_high = 1'b0;
        run = 1;
        ncs_hi_run++;
      end else begin
        if (p2_ncs) begin
          if (ncs_hi_run < CLK_DIV) ncs_err++;
          ncs_hi_run = 0;
          run = 1;
        end else if (sclk == p2_sclk) begin
          run++;
        end else begin
          if (p2_sclk && run != CLK_DIV) phase_err++;
          if (!p2_sclk && seen_high && run != CLK_DIV) phase_err++;
          if (sclk) seen_high = 1'b1;
          run = 1;
        end
        if (!p2_ncs && sclk && (mosi !== p2_mosi)) mosi_err++;
      end
    end
    p2_sclk = sclk; p2_ncs = ncs; p2_mosi = mosi;
  end

  // One request from acceptance to done, checked against the model.
  task automatic run_txn(input logic [1:0] c, input logic [5:0] a, input logic [3:0] l,
                         input logic [7:0] w, input bit inject);
    logic [7:0] exp_tx [$];
    logic [7:0] exp_rd [$];
    logic [7:0] got_rd [$];
    int nd, t0, lat, last_rv, done_cyc;
    bit seen;
`ifdef ADXL362_SPI_MASTER_BURST_EN
    nd = int'(l) + 1;
`else
    nd = 1;
`endif
    if (c == 2'b00) begin
      exp_tx.push_back(8'h0A); exp_tx.push_back({2'b00, a}); exp_tx.push_back(w);
      ref_mem[a] = w;
    end else if (c == 2'b01) begin
      exp_tx.push_back(8'h0B); exp_tx.push_back({2'b00, a});
      for (int j = 0; j < nd; j++) begin
        exp_tx.push_back(8'h00);
        exp_rd.push_back(ref_mem[a + 6'(j)]);
      end
    end else begin
      exp_tx.push_back(8'h0D);
      for (int j = 0; j < nd; j++) begin
        exp_tx.push_back(8'h00);
        exp_rd.push_back(fifo_mem[j % 16]);
      end
    end
    mosi_log.delete();
    start = 1'b1; cmd = c; addr = a; len = l; wr_data = w;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0; cmd = 2'($urandom); addr = 6'($urandom); len = 4'($urandom); wr_data = 8'($urandom);
    check_eq("busy_rise", busy, 1);
    check_eq("ncs_fall", ncs, 0);
    seen = 1'b0; lat = -1; last_rv = -100000; done_cyc = 0;
    for (int k = 0; k < 4000 && !seen; k++) begin
      if (inject && k == 30) begin
        start = 1'b1; cmd = 2'($urandom_range(0, 2));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (rd_valid) begin
        got_rd.push_back(rd_data);
        last_rv = cyc;
      end
      if (done) begin
        seen = 1'b1; done_cyc = cyc; lat = cyc - t0 - 1;
      end
    end
    start = 1'b0;
    check_eq("done_seen", seen, 1);
    check_eq("busy_fall", busy, 0);
    check_eq("latency", lat, CLK_DIV * (3 + 16 * exp_tx.size()));
    check_eq("mosi_count", mosi_log.size(), exp_tx.size());
    for (int j = 0; j < exp_tx.size() && j < mosi_log.size(); j++)
      check_eq("mosi_byte", mosi_log[j], exp_tx[j]);
    check_eq("rd_count", got_rd.size(), exp_rd.size());
    for (int j = 0; j < exp_rd.size() && j < got_rd.size(); j++)
      check_eq("rd_byte", got_rd[j], exp_rd[j]);
    if (exp_rd.size() > 0)
      check_eq("rv_before_done", (done_cyc - last_rv) >= 2 * CLK_DIV, 1);
  endtask

  initial begin
    int bad;
    logic [7:0] v;
    for (int i = 0; i < 64; i++) begin
      v = 8'($urandom);
      ref_mem[i] = v; s_mem[i] = v;
    end
    ref_mem[0] = 8'hAD; s_mem[0] = 8'hAD;
    for (int i = 0; i < 16; i++) fifo_mem[i] = 8'($urandom);

    // Reset with a simultaneous start: reset must win.
    rst = 1'b1; start = 1'b1; cmd = 2'b01; addr = 6'd0; len = 4'd0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_ncs", ncs, 1);
    check_eq("rst_sclk", sclk, 0);
    check_eq("rst_mosi", mosi, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 8'h00);
    start = 1'b0; rst = 1'b0; chk_on = 1'b1;
    repeat (2) @(negedge clk);

    // Directed sequence from the test plan.
    run_txn(2'b00, 6'h2D, 4'd7, 8'h02, 1'b0);
    run_txn(2'b01, 6'h2D, 4'd0, 8'h00, 1'b0);
    run_txn(2'b01, 6'h00, 4'd0, 8'h00, 1'b0);
    run_txn(2'b01, 6'h0E, 4'd5, 8'h00, 1'b0);
    run_txn(2'b10, 6'h00, 4'd3, 8'h00, 1'b0);
    run_txn(2'b01, 6'h20, 4'd15, 8'h00, 1'b1);

    // Reserved command from IDLE: no activity at all.
    repeat (3) @(negedge clk);
    start = 1'b1; cmd = 2'b11; addr = 6'h05;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (ncs !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    check_eq("rsvd_quiet", bad, 0);

    // Reset during the address byte drops the transfer.
    start = 1'b1; cmd = 2'b01; addr = 6'h11; len = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (90) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_ncs", ncs, 1);
    check_eq("mid_rst_sclk", sclk, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_rd_data", rd_data, 8'h00);
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      if (done !== 1'b0 || rd_valid !== 1'b0 || ncs !== 1'b1) bad++;
      @(negedge clk);
    end
    check_eq("mid_rst_quiet", bad, 0);
    run_txn(2'b01, 6'h00, 4'd0, 8'h00, 1'b0);

    // Randomized requests.
    for (int i = 0; i < 10; i++)
      run_txn(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)), 4'($urandom_range(0, 15)),
              8'($urandom), $urandom_range(0, 3) == 0);

    // Nothing may follow the last done.
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check_eq("tail_quiet", bad, 0);
    check_eq("sclk_phase", phase_err, 0);
    check_eq("mosi_stable_high", mosi_err, 0);
    check_eq("ncs_high_time", ncs_err, 0);
    check_eq("sclk_idle_low", idle_sclk_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
